// File: rtl/p2s_share_sched.sv
// p2s_share_sched
//   Shared serializer for the board's two shift-register output chains
//   (7-seg and LED). One shift engine is time-multiplexed between the two
//   chains under round-robin arbitration. A rising edge on refresh marks
//   every chain whose data changed since it was last sent. The first
//   refresh after reset marks both chains.
//
// Ports
//   clk_100mhz          system clock
//   rstn                asynchronous active-low reset
//   refresh             update tick (level; rising edge detected here)
//   seg_data/led_data   parallel words, MSB shifted out first
//   seg_* / led_*       chain pins: clk (shift clock), clrn (clear, active
//                       low), sout (serial data), pen (rising edge latches)
//   busy                engine not idle
//   grant               one-hot owner, [1]=SEG [0]=LED, 00 when idle
module p2s_share_sched #(
  parameter int SEG_BITS = 64,
  parameter int LED_BITS = 16,
  parameter int CNT_W    = 7,
  parameter int HALF     = 2
) (
  input  logic                clk_100mhz,
  input  logic                rstn,
  input  logic                refresh,
  input  logic [SEG_BITS-1:0] seg_data,
  input  logic [LED_BITS-1:0] led_data,
  output logic                seg_clk,
  output logic                seg_clrn,
  output logic                seg_sout,
  output logic                seg_pen,
  output logic                led_clk,
  output logic                led_clrn,
  output logic                led_sout,
  output logic                led_pen,
  output logic                busy,
  output logic [1:0]          grant
);

  localparam int MAXW = (SEG_BITS > LED_BITS) ? SEG_BITS : LED_BITS;
  localparam int HW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [HW-1:0]    HLAST    = HW'(HALF - 1);
  localparam logic [CNT_W-1:0] SEG_LAST = CNT_W'(SEG_BITS - 1);
  localparam logic [CNT_W-1:0] LED_LAST = CNT_W'(LED_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_LO,
    S_HI,
    S_LATCH
  } state_e;

  state_e              state_q, state_d;
  logic                own_seg_q, own_seg_d;    // current owner: 1=SEG, 0=LED
  logic                last_seg_q, last_seg_d;  // last served: 1=SEG, 0=LED
  logic                seg_pend_q, seg_pend_d;
  logic                led_pend_q, led_pend_d;
  logic                force_q, force_d;
  logic                refresh_q;
  logic [MAXW-1:0]     shreg_q, shreg_d;
  logic [SEG_BITS-1:0] seg_shadow_q, seg_shadow_d;
  logic [LED_BITS-1:0] led_shadow_q, led_shadow_d;
  logic [HW-1:0]       hcnt_q, hcnt_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  // Pins are registered from the next-state decode, so they follow the
  // current state cycle-for-cycle without decode glitches on the chain clocks.
  logic seg_clk_q, seg_clrn_q, seg_sout_q, seg_pen_q;
  logic led_clk_q, led_clrn_q, led_sout_q, led_pen_q;
  logic seg_clk_d, seg_sout_d, seg_pen_d;
  logic led_clk_d, led_sout_d, led_pen_d;

  logic ref_rise;
  logic in_frame, act_clk, act_sout;

  always_comb begin
    state_d      = state_q;
    own_seg_d    = own_seg_q;
    last_seg_d   = last_seg_q;
    force_d      = force_q;
    shreg_d      = shreg_q;
    seg_shadow_d = seg_shadow_q;
    led_shadow_d = led_shadow_q;
    hcnt_d       = hcnt_q;
    cnt_d        = cnt_q;

    ref_rise = refresh & ~refresh_q;
    if (ref_rise) force_d = 1'b0;

    // A chain being loaded takes the live data, so any change up to now is
    // covered by this frame and its request can be dropped.
    if (state_q == S_LOAD && own_seg_q) seg_pend_d = 1'b0;
    else seg_pend_d = seg_pend_q | (ref_rise & ((seg_data != seg_shadow_q) | force_q));
    if (state_q == S_LOAD && !own_seg_q) led_pend_d = 1'b0;
    else led_pend_d = led_pend_q | (ref_rise & ((led_data != led_shadow_q) | force_q));

    case (state_q)
      S_IDLE: begin
        if (seg_pend_q || led_pend_q) begin
          state_d   = S_LOAD;
          // On a tie, the chain that was not served last wins.
          own_seg_d = seg_pend_q & (~led_pend_q | ~last_seg_q);
        end
      end
      S_LOAD: begin
        last_seg_d = own_seg_q;
        hcnt_d     = '0;
        cnt_d      = '0;
        state_d    = S_LO;
        if (own_seg_q) begin
          shreg_d      = MAXW'(seg_data) << (MAXW - SEG_BITS);
          seg_shadow_d = seg_data;
        end else begin
          shreg_d      = MAXW'(led_data) << (MAXW - LED_BITS);
          led_shadow_d = led_data;
        end
      end
      S_LO: begin
        if (hcnt_q == HLAST) begin
          hcnt_d  = '0;
          state_d = S_HI;
        end else begin
          hcnt_d = hcnt_q + 1'b1;
        end
      end
      S_HI: begin
        if (hcnt_q == HLAST) begin
          hcnt_d  = '0;
          shreg_d = shreg_q << 1;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == (own_seg_q ? SEG_LAST : LED_LAST)) state_d = S_LATCH;
          else state_d = S_LO;
        end else begin
          hcnt_d = hcnt_q + 1'b1;
        end
      end
      S_LATCH: begin
        if (hcnt_q == HLAST) begin
          hcnt_d  = '0;
          state_d = S_IDLE;
        end else begin
          hcnt_d = hcnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Pin decode of the state being entered; the idle chain sits at pen=1.
    in_frame   = (state_d != S_IDLE);
    act_clk    = (state_d == S_HI);
    act_sout   = ((state_d == S_LO) || (state_d == S_HI)) & shreg_d[MAXW-1];
    seg_pen_d  = ~(in_frame & own_seg_d);
    seg_clk_d  = in_frame & own_seg_d & act_clk;
    seg_sout_d = in_frame & own_seg_d & act_sout;
    led_pen_d  = ~(in_frame & ~own_seg_d);
    led_clk_d  = in_frame & ~own_seg_d & act_clk;
    led_sout_d = in_frame & ~own_seg_d & act_sout;
  end

  always_ff @(posedge clk_100mhz or negedge rstn) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      own_seg_q    <= 1'b0;
      last_seg_q   <= 1'b0;
      seg_pend_q   <= 1'b0;
      led_pend_q   <= 1'b0;
      force_q      <= 1'b1;
      refresh_q    <= 1'b0;
      shreg_q      <= '0;
      seg_shadow_q <= '0;
      led_shadow_q <= '0;
      hcnt_q       <= '0;
      cnt_q        <= '0;
      seg_clk_q    <= 1'b0;
      seg_clrn_q   <= 1'b0;
      seg_sout_q   <= 1'b0;
      seg_pen_q    <= 1'b0;
      led_clk_q    <= 1'b0;
      led_clrn_q   <= 1'b0;
      led_sout_q   <= 1'b0;
      led_pen_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      own_seg_q    <= own_seg_d;
      last_seg_q   <= last_seg_d;
      seg_pend_q   <= seg_pend_d;
      led_pend_q   <= led_pend_d;
      force_q      <= force_d;
      refresh_q    <= refresh;
      shreg_q      <= shreg_d;
      seg_shadow_q <= seg_shadow_d;
      led_shadow_q <= led_shadow_d;
      hcnt_q       <= hcnt_d;
      cnt_q        <= cnt_d;
      seg_clk_q    <= seg_clk_d;
      seg_clrn_q   <= 1'b1;
      seg_sout_q   <= seg_sout_d;
      seg_pen_q    <= seg_pen_d;
      led_clk_q    <= led_clk_d;
      led_clrn_q   <= 1'b1;
      led_sout_q   <= led_sout_d;
      led_pen_q    <= led_pen_d;
    end
  end

  assign seg_clk  = seg_clk_q;
  assign seg_clrn = seg_clrn_q;
  assign seg_sout = seg_sout_q;
  assign seg_pen  = seg_pen_q;
  assign led_clk  = led_clk_q;
  assign led_clrn = led_clrn_q;
  assign led_sout = led_sout_q;
  assign led_pen  = led_pen_q;
  assign busy     = (state_q != S_IDLE);
  assign grant    = busy ? {own_seg_q, ~own_seg_q} : 2'b00;

endmodule

// File: tb/tb_p2s_share_sched.sv
// Directed bench for p2s_share_sched: two instances (HALF=2 and HALF=1)
// share data and reset; frames are captured from the pins and compared
// with hand-computed constants.
module tb_p2s_share_sched;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        refresh0 = 1'b0;
  logic        refresh1 = 1'b0;
  logic [63:0] seg_data = '0;
  logic [15:0] led_data = '0;

  logic d0_seg_clk, d0_seg_clrn, d0_seg_sout, d0_seg_pen;
  logic d0_led_clk, d0_led_clrn, d0_led_sout, d0_led_pen;
  logic d0_busy;
  logic [1:0] d0_grant;
  logic d1_seg_clk, d1_seg_clrn, d1_seg_sout, d1_seg_pen;
  logic d1_led_clk, d1_led_clrn, d1_led_sout, d1_led_pen;
  logic d1_busy;
  logic [1:0] d1_grant;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  p2s_share_sched #(.SEG_BITS(64), .LED_BITS(16), .CNT_W(7), .HALF(2)) dut (
    .clk_100mhz(clk), .rstn(rstn), .refresh(refresh0),
    .seg_data(seg_data), .led_data(led_data),
    .seg_clk(d0_seg_clk), .seg_clrn(d0_seg_clrn), .seg_sout(d0_seg_sout), .seg_pen(d0_seg_pen),
    .led_clk(d0_led_clk), .led_clrn(d0_led_clrn), .led_sout(d0_led_sout), .led_pen(d0_led_pen),
    .busy(d0_busy), .grant(d0_grant)
  );

  p2s_share_sched #(.SEG_BITS(64), .LED_BITS(16), .CNT_W(7), .HALF(1)) dut1 (
    .clk_100mhz(clk), .rstn(rstn), .refresh(refresh1),
    .seg_data(seg_data), .led_data(led_data),
    .seg_clk(d1_seg_clk), .seg_clrn(d1_seg_clrn), .seg_sout(d1_seg_sout), .seg_pen(d1_seg_pen),
    .led_clk(d1_led_clk), .led_clrn(d1_led_clrn), .led_sout(d1_led_sout), .led_pen(d1_led_pen),
    .busy(d1_busy), .grant(d1_grant)
  );

  // Pin view of the chain under observation (p_*) and of the other chain (o_*).
  int   sel_dut = 0;
  int   sel_chain = 1;
  logic p_clk, p_sout, p_pen, o_clk, o_sout, o_pen;
  always_comb begin
    if (sel_dut == 0 && sel_chain == 1) begin
      {p_clk, p_sout, p_pen} = {d0_seg_clk, d0_seg_sout, d0_seg_pen};
      {o_clk, o_sout, o_pen} = {d0_led_clk, d0_led_sout, d0_led_pen};
    end else if (sel_dut == 0) begin
      {p_clk, p_sout, p_pen} = {d0_led_clk, d0_led_sout, d0_led_pen};
      {o_clk, o_sout, o_pen} = {d0_seg_clk, d0_seg_sout, d0_seg_pen};
    end else if (sel_chain == 1) begin
      {p_clk, p_sout, p_pen} = {d1_seg_clk, d1_seg_sout, d1_seg_pen};
      {o_clk, o_sout, o_pen} = {d1_led_clk, d1_led_sout, d1_led_pen};
    end else begin
      {p_clk, p_sout, p_pen} = {d1_led_clk, d1_led_sout, d1_led_pen};
      {o_clk, o_sout, o_pen} = {d1_seg_clk, d1_seg_sout, d1_seg_pen};
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  task automatic pulse_refresh(input int which);
    @(posedge clk); #1;
    if (which == 0) refresh0 = 1'b1; else refresh1 = 1'b1;
    @(posedge clk); #1;
    refresh0 = 1'b0;
    refresh1 = 1'b0;
  endtask

  // Wait for the observed chain's pen to fall, then record the frame until pen rises.
  task automatic run_frame(input int dsel, input int csel, input int period, input int budget,
                           output logic [63:0] bits, output int nbits, output int len,
                           output int waited, output logic [1:0] gseen, output int other_bad,
                           output int stab_bad, output int per_bad, output bit timeout);
    logic prev_clk, prev_sout;
    int   last_rise;
    sel_dut = dsel; sel_chain = csel;
    bits = '0; nbits = 0; len = 0; waited = 0; gseen = 2'b00;
    other_bad = 0; stab_bad = 0; per_bad = 0; timeout = 1'b0;
    do begin
      @(negedge clk);
      waited++;
    end while (p_pen !== 1'b0 && waited < budget);
    if (p_pen !== 1'b0) begin
      timeout = 1'b1;
      return;
    end
    gseen = (dsel == 0) ? d0_grant : d1_grant;
    prev_clk = p_clk; prev_sout = p_sout; last_rise = -1;
    while (p_pen === 1'b0 && len < 1000) begin
      len++;
      if (o_pen !== 1'b1 || o_clk !== 1'b0 || o_sout !== 1'b0) other_bad++;
      @(negedge clk);
      if (p_clk === 1'b1 && prev_clk === 1'b0) begin
        bits = {bits[62:0], p_sout};
        nbits++;
        if (p_sout !== prev_sout) stab_bad++;
        if (last_rise >= 0 && (len - last_rise) != period) per_bad++;
        last_rise = len;
      end
      prev_clk = p_clk; prev_sout = p_sout;
    end
  endtask

  task automatic do_frame(input string tag, input int dsel, input int csel, input int period,
                          input int exp_len, input int exp_nbits, input logic [63:0] exp_bits,
                          input int exp_wait);
    logic [63:0] bits;
    logic [1:0]  gseen;
    int nbits, len, waited, other_bad, stab_bad, per_bad;
    bit timeout;
    run_frame(dsel, csel, period, 60, bits, nbits, len, waited, gseen,
              other_bad, stab_bad, per_bad, timeout);
    check({tag, "_timeout"}, 64'(timeout), 64'd0);
    if (!timeout) begin
      check({tag, "_len"}, 64'(len), 64'(exp_len));
      check({tag, "_nbits"}, 64'(nbits), 64'(exp_nbits));
      check({tag, "_bits"}, bits, exp_bits);
      check({tag, "_grant"}, 64'(gseen), (csel == 1) ? 64'd2 : 64'd1);
      check({tag, "_other_idle"}, 64'(other_bad), 64'd0);
      check({tag, "_sout_stable"}, 64'(stab_bad), 64'd0);
      check({tag, "_clk_period"}, 64'(per_bad), 64'd0);
      if (exp_wait >= 0) check({tag, "_gap"}, 64'(waited), 64'(exp_wait));
    end
  endtask

  task automatic quiet_window(input string tag, input int cycles);
    int busy_cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (d0_busy !== 1'b0 || d0_seg_pen !== 1'b1 || d0_led_pen !== 1'b1) busy_cnt++;
    end
    check(tag, 64'(busy_cnt), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rises, waited, pen_rose;

    // Reset state
    #1;
    check("rst_pins0", 64'({d0_seg_clk, d0_seg_clrn, d0_seg_sout, d0_seg_pen,
                            d0_led_clk, d0_led_clrn, d0_led_sout, d0_led_pen}), 64'd0);
    check("rst_busy_grant0", 64'({d0_busy, d0_grant}), 64'd0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check("rel_clrn", 64'({d0_seg_clrn, d0_led_clrn, d1_seg_clrn, d1_led_clrn}), 64'hF);
    check("rel_idle_pins", 64'({d0_seg_pen, d0_seg_clk, d0_seg_sout, d0_led_pen, d0_led_clk, d0_led_sout}),
          64'b100100);
    check("rel_busy_grant", 64'({d0_busy, d0_grant}), 64'd0);

    // T1: first refresh sends both, SEG first, back-to-back LED
    seg_data = 64'h0123_4567_89AB_CDEF;
    led_data = 16'hA5C3;
    pulse_refresh(0);
    do_frame("t1_seg", 0, 1, 4, 259, 64, 64'h0123_4567_89AB_CDEF, -1);
    do_frame("t1_led", 0, 0, 4, 67, 16, 64'h0000_0000_0000_A5C3, 1);

    // T2: unchanged data, no activity
    pulse_refresh(0);
    quiet_window("t2_quiet", 300);

    // T3: only LED changed
    led_data = 16'h00FF;
    pulse_refresh(0);
    do_frame("t3_led", 0, 0, 4, 67, 16, 64'h0000_0000_0000_00FF, -1);
    quiet_window("t3_quiet_after", 300);

    // T4: both change; SEG changes again mid-frame
    seg_data = 64'hFEDC_BA98_7654_3210;
    led_data = 16'h1234;
    pulse_refresh(0);
    fork
      do_frame("t4_seg_old", 0, 1, 4, 259, 64, 64'hFEDC_BA98_7654_3210, -1);
      begin
        repeat (100) @(posedge clk);
        #1 seg_data = 64'h5555_AAAA_0F0F_F0F0;
        pulse_refresh(0);
      end
    join
    do_frame("t4_led", 0, 0, 4, 67, 16, 64'h0000_0000_0000_1234, 1);
    do_frame("t4_seg_new", 0, 1, 4, 259, 64, 64'h5555_AAAA_0F0F_F0F0, 1);

    // T5: reset asserted at bit 30 of a SEG frame
    seg_data = 64'hDEAD_BEEF_CAFE_F00D;
    pulse_refresh(0);
    waited = 0;
    while (d0_seg_pen !== 1'b0 && waited < 60) begin
      @(negedge clk);
      waited++;
    end
    check("t5_frame_start", 64'(d0_seg_pen), 64'd0);
    rises = 0;
    for (int i = 0; i < 400 && rises < 30; i++) begin
      logic pc;
      pc = d0_seg_clk;
      @(negedge clk);
      if (d0_seg_clk === 1'b1 && pc === 1'b0) rises++;
    end
    check("t5_bit30_reached", 64'(rises), 64'd30);
    rstn = 1'b0;
    #1;
    check("t5_rst_pins0", 64'({d0_seg_clk, d0_seg_clrn, d0_seg_sout, d0_seg_pen,
                               d0_led_clk, d0_led_clrn, d0_led_sout, d0_led_pen}), 64'd0);
    check("t5_rst_busy_grant", 64'({d0_busy, d0_grant}), 64'd0);
    pen_rose = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (d0_seg_pen !== 1'b0 || d0_led_pen !== 1'b0) pen_rose++;
    end
    check("t5_no_pen_in_reset", 64'(pen_rose), 64'd0);
    rstn = 1'b1;
    @(negedge clk);
    pulse_refresh(0);
    do_frame("t5_seg_resend", 0, 1, 4, 259, 64, 64'hDEAD_BEEF_CAFE_F00D, -1);
    do_frame("t5_led_resend", 0, 0, 4, 67, 16, 64'h0000_0000_0000_1234, 1);

    // T6: HALF=1 instance, forced send of both chains
    pulse_refresh(1);
    do_frame("t6_seg", 1, 1, 2, 130, 64, 64'hDEAD_BEEF_CAFE_F00D, -1);
    do_frame("t6_led", 1, 0, 2, 34, 16, 64'h0000_0000_0000_1234, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
